// File: rtl/pms_ext_irq_arbiter.sv
// External interrupt arbiter for the PMS: captures edge/level events into a
// pending vector and offers the lowest enabled pending line as an ID via valid/ready.
module pms_ext_irq_arbiter #(
  parameter int unsigned NUM_EXT_IRQ = 222,
  parameter int unsigned ID_OFFSET   = 34,
  parameter int unsigned ID_WIDTH    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_EXT_IRQ-1:0] irq_i,
  input  logic [NUM_EXT_IRQ-1:0] irq_en_i,
  input  logic [NUM_EXT_IRQ-1:0] irq_edge_i,
  output logic                   irq_valid_o,
  output logic [ID_WIDTH-1:0]    irq_id_o,
  input  logic                   irq_ready_i,
  output logic [NUM_EXT_IRQ-1:0] pending_o
);

  localparam int unsigned IDX_W = (NUM_EXT_IRQ > 1) ? $clog2(NUM_EXT_IRQ) : 1;

  if ((NUM_EXT_IRQ == 0) ||
      ((64'(NUM_EXT_IRQ) + 64'(ID_OFFSET)) > (64'd1 << ID_WIDTH))) begin : g_bad_cfg
    $error("pms_ext_irq_arbiter: NUM_EXT_IRQ/ID_OFFSET do not fit in ID_WIDTH");
  end

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  state_t                 state;
  logic [NUM_EXT_IRQ-1:0] irq_q;
  logic [NUM_EXT_IRQ-1:0] pending;
  logic [NUM_EXT_IRQ-1:0] set_vec;
  logic [NUM_EXT_IRQ-1:0] clr_vec;
  logic [NUM_EXT_IRQ-1:0] eligible;
  logic [IDX_W-1:0]       sel_q;
  logic [IDX_W-1:0]       sel_idx;
  logic                   any_elig;
  logic [ID_WIDTH-1:0]    id_next;
  logic                   valid_q;
  logic [ID_WIDTH-1:0]    id_q;

  assign set_vec  = (irq_edge_i & irq_i & ~irq_q) | (~irq_edge_i & irq_i);
  assign eligible = pending & irq_en_i;
  assign id_next  = ID_WIDTH'(sel_idx) + ID_WIDTH'(ID_OFFSET);

  always_comb begin
    any_elig = 1'b0;
    sel_idx  = '0;
    for (int unsigned i = 0; i < NUM_EXT_IRQ; i++) begin
      if (eligible[i] && !any_elig) begin
        any_elig = 1'b1;
        sel_idx  = i[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    clr_vec = '0;
    if (state == OFFER && irq_ready_i) clr_vec[sel_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q   <= '0;
      pending <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      state   <= IDLE;
    end else begin
      irq_q   <= irq_i;
      // Set is applied after clear so a coincident event re-pends the line.
      pending <= (pending & ~clr_vec) | set_vec;
      case (state)
        IDLE: begin
          if (any_elig) begin
            sel_q   <= sel_idx;
            id_q    <= id_next;
            valid_q <= 1'b1;
            state   <= OFFER;
          end
        end
        OFFER: begin
          if (irq_ready_i) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign irq_valid_o = valid_q;
  assign irq_id_o    = id_q;
  assign pending_o   = pending;

endmodule
